// File: rtl/lcd_frame_capture.sv
// Captures the LCD pixel stream, packs four 2-bit pixels per byte and streams whole frames
// into a byte-wide framebuffer port through a small write FIFO, flagging geometry/drop errors.
module lcd_frame_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13,
    parameter int FIFO_D   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              valid,
    input  logic [1:0]        pixel,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              fb_wr,
    input  logic              fb_ready,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err_overflow,
    output logic              err_geometry
);
    localparam int PW    = $clog2(H_PIXELS + 1);
    localparam int LW    = $clog2(V_LINES + 1);
    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CW    = PTR_W + 1;
    localparam int EW    = ADDR_W + 8;
    localparam logic [PW-1:0]     H_MAX          = PW'(H_PIXELS);
    localparam logic [LW-1:0]     L_MAX          = LW'(V_LINES);
    localparam logic [ADDR_W-1:0] BYTES_PER_LINE = ADDR_W'(H_PIXELS / 4);

    typedef enum logic [1:0] {WAIT_VS, ACTIVE, DRAIN} state_t;

    state_t            state, state_n;
    logic              hs_q, vs_q;
    logic              hs_rise, vs_rise, frame_end;
    logic [PW-1:0]     pix_cnt;
    logic [LW-1:0]     line_cnt;
    logic [5:0]        acc;
    logic              accept, in_range;
    logic [ADDR_W-1:0] byte_addr;
    logic              push_v;
    logic [ADDR_W-1:0] push_addr;
    logic [7:0]        push_data;
    logic [EW-1:0]     mem [FIFO_D];
    logic [EW-1:0]     head;
    logic [PTR_W:0]    wptr, rptr;
    logic              empty, full, pop, push_ok;
    logic [CW-1:0]     cnt_old, cnt_cur, old_n, cur_n;
    logic [1:0]        pend;

    assign hs_rise   = hs & ~hs_q;
    assign vs_rise   = vs & ~vs_q;
    assign frame_end = vs_rise & (state != WAIT_VS);
    assign accept    = valid & ~hs & ~vs & (state != WAIT_VS);
    assign in_range  = (pix_cnt < H_MAX) && (line_cnt < L_MAX);
    assign byte_addr = ADDR_W'(line_cnt) * BYTES_PER_LINE + ADDR_W'(pix_cnt[PW-1:2]);

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign fb_wr   = ~empty;
    assign pop     = fb_wr & fb_ready;
    assign push_ok = push_v & (~full | pop);
    assign head    = mem[rptr[PTR_W-1:0]];
    assign fb_addr  = fb_wr ? head[EW-1:8] : '0;
    assign fb_wdata = fb_wr ? head[7:0] : '0;

    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        case (state)
            WAIT_VS: if (vs_rise) state_n = ACTIVE;
            ACTIVE:  if (vs_rise) state_n = DRAIN;
            DRAIN: begin
                // One pulse per finished frame once all of its entries have left the FIFO.
                if (cnt_old == '0) begin
                    frame_done = 1'b1;
                    if (pend == 2'd1 && !vs_rise) state_n = ACTIVE;
                end
            end
            default: state_n = WAIT_VS;
        endcase
    end

    // FIFO entries are in order, so finished-frame entries are always the oldest cnt_old ones.
    always_comb begin
        old_n = cnt_old;
        cur_n = cnt_cur;
        if (pop) begin
            if (cnt_old != '0) old_n = old_n - CW'(1);
            else               cur_n = cur_n - CW'(1);
        end
        if (push_ok) cur_n = cur_n + CW'(1);
        if (frame_end) begin
            old_n = old_n + cur_n;
            cur_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[PTR_W-1:0]] <= {push_addr, push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_VS;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            acc          <= '0;
            push_v       <= 1'b0;
            push_addr    <= '0;
            push_data    <= '0;
            wptr         <= '0;
            rptr         <= '0;
            cnt_old      <= '0;
            cnt_cur      <= '0;
            pend         <= '0;
            frame_count  <= '0;
            err_overflow <= 1'b0;
            err_geometry <= 1'b0;
        end else begin
            hs_q    <= hs;
            vs_q    <= vs;
            state   <= state_n;
            cnt_old <= old_n;
            cnt_cur <= cur_n;
            if (frame_done) frame_count <= frame_count + 16'd1;
            case ({frame_end, frame_done})
                2'b10:   pend <= pend + 2'd1;
                2'b01:   pend <= pend - 2'd1;
                default: pend <= pend;
            endcase

            if (vs_rise) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                if (state == ACTIVE && line_cnt != L_MAX) err_geometry <= 1'b1;
                if (state == DRAIN) err_geometry <= 1'b1;
            end else if (hs_rise && state != WAIT_VS && pix_cnt != '0) begin
                if (pix_cnt != H_MAX) err_geometry <= 1'b1;
                if (line_cnt != L_MAX) line_cnt <= line_cnt + LW'(1);
                pix_cnt <= '0;
            end else if (accept) begin
                if (pix_cnt != H_MAX) pix_cnt <= pix_cnt + PW'(1);
                if (!in_range) err_geometry <= 1'b1;
            end

            push_v <= accept && in_range && (pix_cnt[1:0] == 2'd3);
            if (accept && in_range) begin
                acc       <= {acc[3:0], pixel};
                push_addr <= byte_addr;
                push_data <= {acc, pixel};
            end

            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_v && full && !pop) err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: expected framebuffer writes are queued as pixels are
// driven and compared in order as the DUT issues them.
module tb_lcd_frame_capture;
    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hs = 1'b0, vs = 1'b0, valid = 1'b0;
    logic [1:0]    pixel = 2'd0;
    logic          fb_ready = 1'b1;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic          fb_wr, frame_done, err_overflow, err_geometry;
    logic [15:0]   frame_count;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    int done_cnt = 0;
    bit seen39 = 1'b0;
    logic [AW+7:0] exp_q[$];

    lcd_frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .FIFO_D(4)) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .valid(valid), .pixel(pixel),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_wr(fb_wr), .fb_ready(fb_ready),
        .frame_done(frame_done), .frame_count(frame_count),
        .err_overflow(err_overflow), .err_geometry(err_geometry)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every accepted write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (!rst && fb_wr && fb_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_write got=%0h/%0h exp=none", fb_addr, fb_wdata);
            end else begin
                e = exp_q.pop_front();
                assert ({fb_addr, fb_wdata} === e) else begin
                    fails++;
                    $error("FAIL fb_write got=%0h/%0h exp=%0h/%0h", fb_addr, fb_wdata,
                           e[AW+7:8], e[7:0]);
                end
            end
            writes++;
            if (fb_addr == AW'(39)) seen39 = 1'b1;
        end
        if (!rst && frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; hs = 1'b0; vs = 1'b0; valid = 1'b0; pixel = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        exp_q.delete();
        writes = 0;
        done_cnt = 0;
        seen39 = 1'b0;
    endtask

    task automatic send_vs();
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
    endtask

    // n pixels with shade i%4 on line l, then one hs pulse; expected bytes only for in-range groups.
    task automatic send_line(input int n, input int l);
        logic [7:0] g;
        g = 8'd0;
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            pixel = 2'(i % 4);
            g = {g[5:0], pixel};
            if (i < H && l < V && i % 4 == 3) exp_q.push_back({AW'(l * (H / 4) + i / 4), g});
            tick();
        end
        valid = 1'b0;
        hs = 1'b1;
        tick();
        hs = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    initial begin
        logic [7:0] g;

        // Reset with random inputs: all outputs held at zero.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            valid = 1'($urandom_range(0, 1));
            pixel = 2'($urandom_range(0, 3));
            fb_ready = 1'($urandom_range(0, 1));
            tick();
            check("rst_fb_wr", fb_wr, 0);
        end
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_geometry", err_geometry, 0);
        hs = 1'b0; vs = 1'b0; valid = 1'b0; pixel = 2'd0; fb_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            pixel = 2'(i % 4);
            tick();
            check("pre_vs_fb_wr", fb_wr, 0);
        end
        valid = 1'b0;
        tick();

        // Backpressure: only the first four bytes fit, the rest are dropped.
        fb_ready = 1'b0;
        send_vs();
        g = 8'd0;
        for (int i = 0; i < 40; i++) begin
            valid = 1'b1;
            pixel = 2'(i % 4);
            g = {g[5:0], pixel};
            if (i < 16 && i % 4 == 3) exp_q.push_back({AW'(i / 4), g});
            tick();
        end
        valid = 1'b0;
        repeat (3) tick();
        check("bp_err_overflow", err_overflow, 1);
        check("bp_fb_wr_held", fb_wr, 1);
        check("bp_fb_addr_head", fb_addr, 0);
        fb_ready = 1'b1;
        repeat (8) tick();
        check("bp_writes", writes, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Short line 0: its last group is lost and line 1 starts at byte 40.
        do_reset();
        send_vs();
        send_line(156, 0);
        check("short_line_err_geometry", err_geometry, 1);
        send_line(160, 1);
        repeat (5) tick();
        check("short_line_writes", writes, 79);
        check("short_line_addr39_unwritten", seen39, 0);
        check("short_line_queue_empty", exp_q.size(), 0);
        check("short_line_err_overflow", err_overflow, 0);

        // 143-line frame: geometry error, one frame_done, next frame restarts at address 0.
        do_reset();
        send_vs();
        for (int l = 0; l < V - 1; l++) send_line(H, l);
        send_vs();
        wait_done(1, "short_frame_done");
        check("short_frame_err_geometry", err_geometry, 1);
        check("short_frame_count", frame_count, 1);
        check("short_frame_writes", writes, (V - 1) * (H / 4));
        for (int l = 0; l < 70; l++) send_line(H, l);
        check("next_frame_single_done", done_cnt, 1);

        // Reset at line 70, then one clean full frame.
        do_reset();
        check("mid_reset_frame_count", frame_count, 0);
        check("mid_reset_err_geometry", err_geometry, 0);
        send_vs();
        for (int l = 0; l < V; l++) send_line(H, l);
        send_vs();
        wait_done(1, "full_frame_done");
        repeat (5) tick();
        check("full_frame_single_done", done_cnt, 1);
        check("full_frame_count", frame_count, 1);
        check("full_frame_writes", writes, H * V / 4);
        check("full_frame_queue_empty", exp_q.size(), 0);
        check("full_frame_err_geometry", err_geometry, 0);
        check("full_frame_err_overflow", err_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
